approx_mul_err_monitor: RTL and testbench

- Downstream consumer of the 8x8 approximate Dadda-tree multiplier.
- Takes each operand pair together with the approximate product the multiplier computed for it, and computes the exact product internally.
- Over a programmed number of samples, accumulates error metrics: erroneous-sample count, sum of error distance, maximum error distance with its operands.
- Used in simulation and on FPGA to characterise approximate full-adder configurations.

---
 rtl/approx_mul_err_monitor.sv | 270 +++++++++++++++++++++++++++
 tb/tb_approx_mul_err_monitor.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_err_monitor.sv
// approx_mul_err_monitor
// Error-statistics monitor for an 8x8 approximate multiplier. Each accepted
// (op_a, op_b, approx_prod) triple is compared against the exact product,
// and a programmed-length run accumulates:
//   - the count of erroneous samples
//   - the saturating sum of error distance (ED = |a*b - approx|)
//   - the largest ED seen, with the operands that produced it
// Pipeline: S1 registers the operands and the exact product, S2 registers
// the ED, and the accumulators update one edge later. There are no stalls.
// Optional build macro ERR_BIAS_EN adds bias_sum, a saturating signed sum
// of (approx - exact). Its saturation also sets sum_sat.

module approx_mul_err_monitor #(
    parameter int W     = 8,
    parameter int CNT_W = 24,
    parameter int SUM_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       op_a,
    input  logic [W-1:0]       op_b,
    input  logic [2*W-1:0]     approx_prod,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [SUM_W-1:0]   ed_sum,
    output logic               sum_sat,
    output logic [2*W-1:0]     ed_max,
    output logic [W-1:0]       max_a,
    output logic [W-1:0]       max_b
`ifdef ERR_BIAS_EN
    ,
    output logic signed [SUM_W-1:0] bias_sum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] accepted_q;
    logic             start_acc;
    logic             xfer;
    logic             last_xfer;

    // Stage 1: captured triple plus its exact product.
    logic             v1;
    logic [W-1:0]     a1, b1;
    logic [2*W-1:0]   p1;
    logic [2*W-1:0]   exact1;

    // Stage 2: error distance and signed error.
    logic               v2;
    logic [W-1:0]       a2, b2;
    logic [2*W-1:0]     ed2;
    logic signed [2*W:0] err2;

    // Stage 1 arithmetic, evaluated at 2W+1 bits so the sign survives.
    logic [2*W:0]     diff1;      // exact - approx
    logic [2*W:0]     neg1;       // approx - exact
    logic [2*W-1:0]   ed1;

    // Accumulator arithmetic.
    logic [SUM_W:0]   sum_ext;
    logic             ed_ovf;
    logic             sat_hit;

`ifdef ERR_BIAS_EN
    logic signed [SUM_W:0] err_ext;
    logic signed [SUM_W:0] bias_ext;
    logic                  bias_pos_ovf;
    logic                  bias_neg_ovf;
    logic signed [SUM_W-1:0] bias_next;
`endif

    // ------------------------------------------------------------------
    // Handshake and status decode. Everything here comes from registers.
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == S_RUN) && (accepted_q != target_q);
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign xfer      = in_valid && in_ready;
    assign last_xfer = xfer && ((accepted_q + CNT_W'(1)) == target_q);
    assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Next-state logic for the run-control FSM.
    always_comb begin
        // NOTE: every signal written in this block gets a default first, so
        // no path through the case statement can leave it unassigned and
        // infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (num_samples == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_xfer) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!v1 && !v2) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the pre-edge values regardless of block order.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run target and accepted-transfer counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q   <= '0;
            accepted_q <= '0;
        end else if (start_acc) begin
            target_q   <= num_samples;
            accepted_q <= '0;
        end else if (xfer) begin
            accepted_q <= accepted_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Datapath pipeline
    // ------------------------------------------------------------------

    // Stage-1 valid flag. The pipeline is always empty when a run starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
        end else begin
            v1 <= xfer;
        end
    end

    // Stage-1 payload: triple and exact product, loaded on a transfer.
    always_ff @(posedge clk) begin
        // NOTE: payload registers are qualified by the valid flags, which do
        // reset. The payload itself needs no reset and loads only on a
        // transfer.
        if (xfer) begin
            a1     <= op_a;
            b1     <= op_b;
            p1     <= approx_prod;
            exact1 <= (2*W)'(op_a) * (2*W)'(op_b);
        end
    end

    // Signed difference and its magnitude, computed from the stage-1 registers.
    always_comb begin
        diff1 = {1'b0, exact1} - {1'b0, p1};
        neg1  = {1'b0, p1} - {1'b0, exact1};
        ed1   = diff1[2*W] ? neg1[2*W-1:0] : diff1[2*W-1:0];
    end

    // Stage-2 valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
        end
    end

    // Stage-2 payload: ED, signed error and the operands that produced them.
    always_ff @(posedge clk) begin
        if (v1) begin
            a2   <= a1;
            b2   <= b1;
            ed2  <= ed1;
            err2 <= $signed(neg1);
        end
    end

    // ------------------------------------------------------------------
    // Accumulators
    // ------------------------------------------------------------------

    // Saturating ED sum and optional saturating signed bias sum.
    always_comb begin
        sum_ext = {1'b0, ed_sum} + (SUM_W+1)'(ed2);
        ed_ovf  = sum_ext[SUM_W];
        sat_hit = ed_ovf;
`ifdef ERR_BIAS_EN
        err_ext      = (SUM_W+1)'(err2);
        bias_ext     = {bias_sum[SUM_W-1], bias_sum} + err_ext;
        bias_pos_ovf = !bias_ext[SUM_W] &&  bias_ext[SUM_W-1];
        bias_neg_ovf =  bias_ext[SUM_W] && !bias_ext[SUM_W-1];
        if (bias_pos_ovf) begin
            bias_next = {1'b0, {(SUM_W-1){1'b1}}};
        end else if (bias_neg_ovf) begin
            bias_next = {1'b1, {(SUM_W-1){1'b0}}};
        end else begin
            bias_next = bias_ext[SUM_W-1:0];
        end
        sat_hit = ed_ovf || bias_pos_ovf || bias_neg_ovf;
`endif
    end

    // Statistics registers: cleared by an accepted start, updated from stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            ed_sum     <= '0;
            sum_sat    <= 1'b0;
            ed_max     <= '0;
            max_a      <= '0;
            max_b      <= '0;
        end else if (start_acc) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            ed_sum     <= '0;
            sum_sat    <= 1'b0;
            ed_max     <= '0;
            max_a      <= '0;
            max_b      <= '0;
        end else if (v2) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (ed2 != '0) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            ed_sum  <= ed_ovf ? '1 : sum_ext[SUM_W-1:0];
            sum_sat <= sum_sat || sat_hit;
            // Strictly greater only: on a tie the first occurrence is kept.
            if (ed2 > ed_max) begin
                ed_max <= ed2;
                max_a  <= a2;
                max_b  <= b2;
            end
        end
    end

`ifdef ERR_BIAS_EN
    // Signed bias accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_sum <= '0;
        end else if (start_acc) begin
            bias_sum <= '0;
        end else if (v2) begin
            bias_sum <= bias_next;
        end
    end
`endif

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// tb_approx_mul_err_monitor
// Self-checking bench for approx_mul_err_monitor. The stimulus is directed
// and randomized. Expected statistics come from a plain-arithmetic model
// that is updated on every handshake the bench observes. A second instance
// with SUM_W=17 exercises ED-sum saturation.

module tb_approx_mul_err_monitor;

    localparam int W      = 8;
    localparam int CNT_W  = 24;
    localparam int SUM_W  = 32;
    localparam int SUM_WS = 17;

    logic               clk;
    logic               rst;
    logic               start;
    logic [CNT_W-1:0]   num_samples;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic [2*W-1:0]     approx_prod;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   sample_cnt;
    logic [CNT_W-1:0]   err_cnt;
    logic [SUM_W-1:0]   ed_sum;
    logic               sum_sat;
    logic [2*W-1:0]     ed_max;
    logic [W-1:0]       max_a;
    logic [W-1:0]       max_b;

    // Outputs of the narrow-sum instance.
    logic               s_in_ready;
    logic               s_busy;
    logic               s_done;
    logic [CNT_W-1:0]   s_sample_cnt;
    logic [CNT_W-1:0]   s_err_cnt;
    logic [SUM_WS-1:0]  s_ed_sum;
    logic               s_sum_sat;
    logic [2*W-1:0]     s_ed_max;
    logic [W-1:0]       s_max_a;
    logic [W-1:0]       s_max_b;

`ifdef ERR_BIAS_EN
    logic signed [SUM_W-1:0]  bias_sum;
    logic signed [SUM_WS-1:0] s_bias_sum;
`endif

    approx_mul_err_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .approx_prod (approx_prod),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .err_cnt     (err_cnt),
        .ed_sum      (ed_sum),
        .sum_sat     (sum_sat),
        .ed_max      (ed_max),
        .max_a       (max_a),
        .max_b       (max_b)
`ifdef ERR_BIAS_EN
        ,
        .bias_sum    (bias_sum)
`endif
    );

    approx_mul_err_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_WS)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .in_valid    (in_valid),
        .in_ready    (s_in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .approx_prod (approx_prod),
        .busy        (s_busy),
        .done        (s_done),
        .sample_cnt  (s_sample_cnt),
        .err_cnt     (s_err_cnt),
        .ed_sum      (s_ed_sum),
        .sum_sat     (s_sum_sat),
        .ed_max      (s_ed_max),
        .max_a       (s_max_a),
        .max_b       (s_max_b)
`ifdef ERR_BIAS_EN
        ,
        .bias_sum    (s_bias_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: statistics over the accepted samples.
    // ------------------------------------------------------------------
    longint m_cnt, m_err, m_total, m_max, m_bias;
    longint m_a, m_b;
    bit     m_bias_sat;
    localparam longint SUM_MAX  = (64'd1 << SUM_W) - 1;
    localparam longint BIAS_MAX = (64'd1 << (SUM_W - 1)) - 1;
    localparam longint BIAS_MIN = -(64'd1 << (SUM_W - 1));

    task automatic model_clear();
        m_cnt = 0; m_err = 0; m_total = 0; m_max = 0; m_bias = 0;
        m_a = 0; m_b = 0; m_bias_sat = 0;
    endtask

    task automatic model_accept(input int a, input int b, input int p);
        longint exact, ed;
        exact = longint'(a) * longint'(b);
        ed    = (exact > p) ? exact - p : p - exact;
        m_cnt++;
        if (ed != 0) m_err++;
        m_total += ed;
        if (ed > m_max) begin
            m_max = ed; m_a = a; m_b = b;
        end
        m_bias += longint'(p) - exact;
        if (m_bias > BIAS_MAX) begin m_bias = BIAS_MAX; m_bias_sat = 1; end
        if (m_bias < BIAS_MIN) begin m_bias = BIAS_MIN; m_bias_sat = 1; end
    endtask

    task automatic check_stats(input string tag);
        bit exp_sat;
        exp_sat = (m_total > SUM_MAX);
`ifdef ERR_BIAS_EN
        exp_sat = exp_sat || m_bias_sat;
        check({tag, "_bias"}, 64'(bias_sum), 64'(m_bias));
`endif
        check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'(m_cnt));
        check({tag, "_err_cnt"},    64'(err_cnt),    64'(m_err));
        check({tag, "_ed_sum"},     64'(ed_sum),     64'((m_total > SUM_MAX) ? SUM_MAX : m_total));
        check({tag, "_sum_sat"},    64'(sum_sat),    64'(exp_sat));
        check({tag, "_ed_max"},     64'(ed_max),     64'(m_max));
        check({tag, "_max_a"},      64'(max_a),      64'(m_a));
        check({tag, "_max_b"},      64'(max_b),      64'(m_b));
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int q_a[$], q_b[$], q_p[$];

    task automatic push(input int a, input int b, input int p);
        q_a.push_back(a); q_b.push_back(b); q_p.push_back(p);
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1;
        num_samples = CNT_W'(n);
        model_clear();
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer the queued triples, with optional idle gaps, for at most max_cycles.
    task automatic feed(input int max_cycles, input bit gaps, output int n_xfer);
        n_xfer = 0;
        for (int c = 0; c < max_cycles && q_a.size() > 0; c++) begin
            @(negedge clk);
            if (gaps && $urandom_range(3) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid    = 1'b1;
                op_a        = W'(q_a[0]);
                op_b        = W'(q_b[0]);
                approx_prod = (2*W)'(q_p[0]);
            end
            if (in_valid && in_ready) begin
                model_accept(q_a[0], q_b[0], q_p[0]);
                void'(q_a.pop_front()); void'(q_b.pop_front()); void'(q_p.pop_front());
                n_xfer++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 50 && !done; c++) @(negedge clk);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        op_a = '0; op_b = '0; approx_prod = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_done",     64'(done),     64'd0);
        check("rst_ed_sum",   64'(ed_sum),   64'd0);
        check("rst_ed_max",   64'(ed_max),   64'd0);
        rst = 1'b0;

        // Exact products.
        do_start(4);
        check("exact_busy", 64'(busy), 64'd1);
        push(3, 5, 15); push(255, 255, 65025); push(0, 7, 0); push(16, 16, 256);
        feed(40, 1'b0, n);
        check("exact_xfers", 64'(n), 64'd4);
        wait_done("exact");
        check_stats("exact");
        check("exact_err_lit", 64'(err_cnt), 64'd0);

        // Known errors, with random gaps.
        do_start(3);
        push(10, 10, 90); push(255, 255, 0); push(2, 2, 4);
        feed(60, 1'b1, n);
        check("known_xfers", 64'(n), 64'd3);
        wait_done("known");
        check_stats("known");
        check("known_sum_lit", 64'(ed_sum), 64'd65035);
        check("known_maxa_lit", 64'(max_a), 64'd255);

        // Saturation on the SUM_W=17 instance.
        do_start(3);
        push(255, 255, 0); push(255, 255, 0); push(255, 255, 0);
        feed(40, 1'b0, n);
        wait_done("sat");
        check_stats("sat_wide");
        check("sat_s_done",    64'(s_done),       64'd1);
        check("sat_s_ed_sum",  64'(s_ed_sum),     64'd131071);
        check("sat_s_sum_sat", 64'(s_sum_sat),    64'd1);
        check("sat_s_cnt",     64'(s_sample_cnt), 64'd3);

        // Zero-length run straight from DONE.
        do_start(0);
        check("zero_done", 64'(done), 64'd1);
        check_stats("zero");
        for (int c = 0; c < 3; c++) begin
            check("zero_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end

        // Backpressure: in_valid held high with more data than the target.
        do_start(2);
        push(1, 2, 2); push(3, 4, 13); push(5, 6, 30); push(7, 8, 56);
        feed(12, 1'b0, n);
        check("bp_xfers", 64'(n), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        q_a.delete(); q_b.delete(); q_p.delete();
        wait_done("bp");
        check_stats("bp");

        // ED tie: the first occurrence keeps max_a/max_b.
        do_start(2);
        push(3, 3, 0); push(1, 9, 0);
        feed(20, 1'b0, n);
        wait_done("tie");
        check_stats("tie");

        // start during RUN is ignored.
        do_start(2);
        push(9, 9, 80);
        feed(20, 1'b0, n);
        @(negedge clk); start = 1'b1; num_samples = '0;
        @(negedge clk); start = 1'b0;
        check("ign_busy", 64'(busy), 64'd1);
        check("ign_done", 64'(done), 64'd0);
        push(20, 20, 410);
        feed(20, 1'b0, n);
        wait_done("ign");
        check_stats("ign");

        // Reset mid-run after one of three samples.
        do_start(3);
        push(7, 9, 60);
        feed(20, 1'b0, n);
        repeat (3) @(negedge clk);
        check("mid_cnt_before", 64'(sample_cnt), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",     64'(busy),       64'd0);
        check("mid_rst_in_ready", 64'(in_ready),   64'd0);
        check("mid_rst_cnt",      64'(sample_cnt), 64'd0);
        check("mid_rst_err",      64'(err_cnt),    64'd0);
        check("mid_rst_sum",      64'(ed_sum),     64'd0);
        check("mid_rst_max",      64'(ed_max),     64'd0);
        check("mid_rst_maxa",     64'(max_a),      64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_start(1);
        push(4, 4, 15);
        feed(20, 1'b0, n);
        wait_done("post");
        check_stats("post");
        check("post_sum_lit", 64'(ed_sum), 64'd1);

        // Randomized run with gaps and assorted error shapes.
        do_start(300);
        for (int i = 0; i < 300; i++) begin
            int a, b, e, p;
            a = $urandom_range(255);
            b = $urandom_range(255);
            e = a * b;
            case ($urandom_range(3))
                0: p = e;
                1: p = (e + $urandom_range(300) > 65535) ? 65535 : e + $urandom_range(300);
                2: p = (e < 300) ? 0 : e - $urandom_range(300);
                default: p = $urandom_range(65535);
            endcase
            push(a, b, p);
        end
        feed(2000, 1'b1, n);
        check("rand_xfers", 64'(n), 64'd300);
        wait_done("rand");
        check_stats("rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
